// File: rtl/cache_miss_controller.sv
// Miss sequencer for a 2-way set-associative cache: lookup, hit update, dirty-victim
// writeback, refill over a single req/ack memory port, and saturating hit/miss/writeback counters.
module cache_miss_controller #(
    parameter int TAG_W  = 3,
    parameter int IDX_W  = 1,
    parameter int DATA_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_req_valid,
    input  logic                    cpu_req_we,
    input  logic [TAG_W+IDX_W-1:0]  cpu_req_addr,
    input  logic [DATA_W-1:0]       cpu_req_wdata,
    output logic                    cpu_ready,
    output logic                    cpu_resp_valid,
    output logic [DATA_W-1:0]       cpu_resp_rdata,
    output logic                    cpu_resp_hit,
    output logic [IDX_W-1:0]        lk_index,
    output logic [TAG_W-1:0]        lk_tag,
    input  logic                    lk_hit,
    input  logic                    lk_hit_way,
    input  logic [DATA_W-1:0]       lk_hit_data,
    input  logic                    lk_vic_way,
    input  logic                    lk_vic_dirty,
    input  logic [TAG_W-1:0]        lk_vic_tag,
    input  logic [DATA_W-1:0]       lk_vic_data,
    output logic                    upd_en,
    output logic                    upd_way,
    output logic                    upd_we,
    output logic [DATA_W-1:0]       upd_wdata,
    output logic                    fill_en,
    output logic                    fill_way,
    output logic [TAG_W-1:0]        fill_tag,
    output logic [DATA_W-1:0]       fill_data,
    output logic                    fill_dirty,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [TAG_W+IDX_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_W-1:0]       mem_rdata,
    output logic                    wback,
    output logic [CNT_W-1:0]        hit_count,
    output logic [CNT_W-1:0]        miss_count,
    output logic [CNT_W-1:0]        wback_count
);
    localparam int ADDR_W = TAG_W + IDX_W;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, FILL, RESPOND} state_t;

    state_t              state_q;
    logic                req_we_q;
    logic [ADDR_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_wdata_q;
    logic                vic_way_q;
    logic                cpu_ready_q, resp_valid_q, resp_hit_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                upd_en_q, upd_way_q, upd_we_q;
    logic [DATA_W-1:0]   upd_wdata_q;
    logic                fill_en_q, fill_way_q, fill_dirty_q;
    logic [TAG_W-1:0]    fill_tag_q;
    logic [DATA_W-1:0]   fill_data_q;
    logic                mem_req_q, mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                wback_q;
    logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q, wb_cnt_q;

    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    assign req_tag = req_addr_q[ADDR_W-1:IDX_W];
    assign req_idx = req_addr_q[IDX_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            req_we_q     <= 1'b0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            vic_way_q    <= 1'b0;
            cpu_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_rdata_q <= '0;
            upd_en_q     <= 1'b0;
            upd_way_q    <= 1'b0;
            upd_we_q     <= 1'b0;
            upd_wdata_q  <= '0;
            fill_en_q    <= 1'b0;
            fill_way_q   <= 1'b0;
            fill_dirty_q <= 1'b0;
            fill_tag_q   <= '0;
            fill_data_q  <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wback_q      <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            wb_cnt_q     <= '0;
        end else begin
            // single-cycle strobes default low
            resp_valid_q <= 1'b0;
            upd_en_q     <= 1'b0;
            fill_en_q    <= 1'b0;
            wback_q      <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu_req_valid) begin
                        req_we_q    <= cpu_req_we;
                        req_addr_q  <= cpu_req_addr;
                        req_wdata_q <= cpu_req_wdata;
                        cpu_ready_q <= 1'b0;
                        state_q     <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (lk_hit) begin
                        upd_en_q     <= 1'b1;
                        upd_way_q    <= lk_hit_way;
                        upd_we_q     <= req_we_q;
                        upd_wdata_q  <= req_wdata_q;
                        resp_rdata_q <= req_we_q ? req_wdata_q : lk_hit_data;
                        resp_hit_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        hit_cnt_q    <= sat_inc(hit_cnt_q);
                        state_q      <= RESPOND;
                    end else begin
                        vic_way_q    <= lk_vic_way;
                        resp_hit_q   <= 1'b0;
                        miss_cnt_q   <= sat_inc(miss_cnt_q);
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= lk_vic_dirty;
                        mem_addr_q   <= lk_vic_dirty ? {lk_vic_tag, req_idx} : req_addr_q;
                        mem_wdata_q  <= lk_vic_data;
                        state_q      <= lk_vic_dirty ? WRITEBACK : REFILL;
                    end
                end
                WRITEBACK: begin
                    // request stays asserted; only the direction and address switch to the refill
                    if (mem_ack) begin
                        wback_q    <= 1'b1;
                        wb_cnt_q   <= sat_inc(wb_cnt_q);
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= req_addr_q;
                        state_q    <= REFILL;
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        mem_req_q    <= 1'b0;
                        fill_en_q    <= 1'b1;
                        fill_way_q   <= vic_way_q;
                        fill_tag_q   <= req_tag;
                        fill_data_q  <= req_we_q ? req_wdata_q : mem_rdata;
                        fill_dirty_q <= req_we_q;
                        resp_rdata_q <= req_we_q ? req_wdata_q : mem_rdata;
                        state_q      <= FILL;
                    end
                end
                FILL: begin
                    resp_valid_q <= 1'b1;
                    state_q      <= RESPOND;
                end
                RESPOND: begin
                    cpu_ready_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    cpu_ready_q <= 1'b1;
                    mem_req_q   <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign cpu_ready      = cpu_ready_q;
    assign cpu_resp_valid = resp_valid_q;
    assign cpu_resp_rdata = resp_rdata_q;
    assign cpu_resp_hit   = resp_hit_q;
    assign lk_index       = req_idx;
    assign lk_tag         = req_tag;
    assign upd_en         = upd_en_q;
    assign upd_way        = upd_way_q;
    assign upd_we         = upd_we_q;
    assign upd_wdata      = upd_wdata_q;
    assign fill_en        = fill_en_q;
    assign fill_way       = fill_way_q;
    assign fill_tag       = fill_tag_q;
    assign fill_data      = fill_data_q;
    assign fill_dirty     = fill_dirty_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign wback          = wback_q;
    assign hit_count      = hit_cnt_q;
    assign miss_count     = miss_cnt_q;
    assign wback_count    = wb_cnt_q;
endmodule

// File: tb/tb_cache_miss_controller.sv
// Scoreboard bench for cache_miss_controller: bench plays the tag arrays and main memory,
// a second instance with 2-bit counters exercises counter saturation.
module tb_cache_miss_controller;
    logic       clock = 1'b0;
    logic       reset;
    logic       cpu_req_valid, cpu_req_we;
    logic [3:0] cpu_req_addr;
    logic [2:0] cpu_req_wdata;
    logic       cpu_ready, cpu_resp_valid, cpu_resp_hit;
    logic [2:0] cpu_resp_rdata;
    logic [0:0] lk_index;
    logic [2:0] lk_tag;
    logic       lk_hit, lk_hit_way, lk_vic_way, lk_vic_dirty;
    logic [2:0] lk_hit_data, lk_vic_tag, lk_vic_data;
    logic       upd_en, upd_way, upd_we;
    logic [2:0] upd_wdata;
    logic       fill_en, fill_way, fill_dirty;
    logic [2:0] fill_tag, fill_data;
    logic       mem_req, mem_we, mem_ack;
    logic [3:0] mem_addr;
    logic [2:0] mem_wdata, mem_rdata;
    logic       wback;
    logic [7:0] hit_count, miss_count, wback_count;

    logic       d2_cpu_ready, d2_resp_valid, d2_resp_hit;
    logic [2:0] d2_resp_rdata;
    logic [0:0] d2_lk_index;
    logic [2:0] d2_lk_tag;
    logic       d2_upd_en, d2_upd_way, d2_upd_we;
    logic [2:0] d2_upd_wdata;
    logic       d2_fill_en, d2_fill_way, d2_fill_dirty;
    logic [2:0] d2_fill_tag, d2_fill_data;
    logic       d2_mem_req, d2_mem_we;
    logic [3:0] d2_mem_addr;
    logic [2:0] d2_mem_wdata;
    logic       d2_wback;
    logic [1:0] d2_hit_count, d2_miss_count, d2_wback_count;

    cache_miss_controller #(.TAG_W(3), .IDX_W(1), .DATA_W(3), .CNT_W(8)) dut (
        .clock(clock), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_ready(cpu_ready), .cpu_resp_valid(cpu_resp_valid),
        .cpu_resp_rdata(cpu_resp_rdata), .cpu_resp_hit(cpu_resp_hit),
        .lk_index(lk_index), .lk_tag(lk_tag),
        .lk_hit(lk_hit), .lk_hit_way(lk_hit_way), .lk_hit_data(lk_hit_data),
        .lk_vic_way(lk_vic_way), .lk_vic_dirty(lk_vic_dirty),
        .lk_vic_tag(lk_vic_tag), .lk_vic_data(lk_vic_data),
        .upd_en(upd_en), .upd_way(upd_way), .upd_we(upd_we), .upd_wdata(upd_wdata),
        .fill_en(fill_en), .fill_way(fill_way), .fill_tag(fill_tag),
        .fill_data(fill_data), .fill_dirty(fill_dirty),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wback(wback),
        .hit_count(hit_count), .miss_count(miss_count), .wback_count(wback_count)
    );

    cache_miss_controller #(.TAG_W(3), .IDX_W(1), .DATA_W(3), .CNT_W(2)) dut2 (
        .clock(clock), .reset(reset),
        .cpu_req_valid(cpu_req_valid), .cpu_req_we(cpu_req_we),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .cpu_ready(d2_cpu_ready), .cpu_resp_valid(d2_resp_valid),
        .cpu_resp_rdata(d2_resp_rdata), .cpu_resp_hit(d2_resp_hit),
        .lk_index(d2_lk_index), .lk_tag(d2_lk_tag),
        .lk_hit(lk_hit), .lk_hit_way(lk_hit_way), .lk_hit_data(lk_hit_data),
        .lk_vic_way(lk_vic_way), .lk_vic_dirty(lk_vic_dirty),
        .lk_vic_tag(lk_vic_tag), .lk_vic_data(lk_vic_data),
        .upd_en(d2_upd_en), .upd_way(d2_upd_way), .upd_we(d2_upd_we), .upd_wdata(d2_upd_wdata),
        .fill_en(d2_fill_en), .fill_way(d2_fill_way), .fill_tag(d2_fill_tag),
        .fill_data(d2_fill_data), .fill_dirty(d2_fill_dirty),
        .mem_req(d2_mem_req), .mem_we(d2_mem_we), .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .wback(d2_wback),
        .hit_count(d2_hit_count), .miss_count(d2_miss_count), .wback_count(d2_wback_count)
    );

    always #5 clock = ~clock;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // scoreboards: resp {hit,rdata}, upd {way,we,wdata}, fill {way,tag,data,dirty}, mem {we,addr,wdata}
    logic [3:0] resp_q[$];
    logic [4:0] upd_q[$];
    logic [7:0] fill_q[$];
    logic [7:0] mem_q[$];

    int exp_hit = 0, exp_miss = 0, exp_wb = 0;
    int wb_seen = 0;
    int acc_cnt = 0;
    bit mreq_seen = 0;
    int dly_wb = 1, dly_rf = 1;
    logic [2:0] mem_rdata_cfg = 3'd0;

    // main-memory model: ack after a programmed number of request cycles
    bit ack_drv = 0;
    int mcnt = 0;
    logic [7:0] mem_e;
    always @(negedge clock) begin
        if (reset) begin
            mem_ack = 1'b0; ack_drv = 0; mcnt = 0;
        end else if (ack_drv) begin
            mem_ack = 1'b0; ack_drv = 0; mcnt = 0;
        end else if (mem_req) begin
            mreq_seen = 1;
            mcnt++;
            if (mcnt >= (mem_we ? dly_wb : dly_rf)) begin
                if (mem_q.size() == 0) check_eq("mem_unexpected", 1, 0);
                else begin
                    mem_e = mem_q.pop_front();
                    check_eq("mem_op", {mem_we, mem_addr, mem_we ? mem_wdata : 3'd0}, mem_e);
                end
                mem_rdata = mem_rdata_cfg;
                mem_ack = 1'b1;
                ack_drv = 1;
            end
        end else begin
            mcnt = 0;
        end
    end

    always @(posedge clock)
        if (!reset && cpu_req_valid && cpu_ready) acc_cnt++;

    logic [7:0] mon_e;
    always @(negedge clock) begin
        if (!reset) begin
            if (cpu_resp_valid) begin
                if (resp_q.size() == 0) check_eq("resp_unexpected", 1, 0);
                else begin
                    mon_e = {4'd0, resp_q.pop_front()};
                    check_eq("resp_rdata", cpu_resp_rdata, mon_e[2:0]);
                    check_eq("resp_hit", cpu_resp_hit, mon_e[3]);
                end
            end
            if (upd_en) begin
                if (upd_q.size() == 0) check_eq("upd_unexpected", 1, 0);
                else begin
                    mon_e = {3'd0, upd_q.pop_front()};
                    check_eq("upd", {upd_way, upd_we, upd_wdata}, mon_e[4:0]);
                end
            end
            if (fill_en) begin
                if (fill_q.size() == 0) check_eq("fill_unexpected", 1, 0);
                else begin
                    mon_e = fill_q.pop_front();
                    check_eq("fill", {fill_way, fill_tag, fill_data, fill_dirty}, mon_e);
                end
            end
            if (upd_en || fill_en) check_eq("upd_fill_exclusive", upd_en & fill_en, 0);
            if (wback) wb_seen++;
        end
    end

    task automatic check_counters(input string tag);
        check_eq({tag, "_hit_cnt"}, hit_count, exp_hit);
        check_eq({tag, "_miss_cnt"}, miss_count, exp_miss);
        check_eq({tag, "_wb_cnt"}, wback_count, exp_wb);
        check_eq({tag, "_hit_cnt2"}, d2_hit_count, (exp_hit > 3) ? 3 : exp_hit);
        check_eq({tag, "_miss_cnt2"}, d2_miss_count, (exp_miss > 3) ? 3 : exp_miss);
    endtask

    task automatic do_access(input string tag, input logic we, input logic [3:0] addr,
                             input logic [2:0] wdata, input logic hit, input logic hway,
                             input logic [2:0] hdata, input logic vdirty, input logic vway,
                             input logic [2:0] vtag, input logic [2:0] vdata,
                             input logic [2:0] mrdata, input int dw, input int dr, input bit hold);
        int cyc;
        int exp_lat;
        int wb0;
        int acc0;
        logic [2:0] rd;
        lk_hit = hit; lk_hit_way = hway; lk_hit_data = hdata;
        lk_vic_way = vway; lk_vic_dirty = vdirty; lk_vic_tag = vtag; lk_vic_data = vdata;
        mem_rdata_cfg = mrdata; dly_wb = dw; dly_rf = dr;
        rd = we ? wdata : (hit ? hdata : mrdata);
        resp_q.push_back({hit, rd});
        if (hit) begin
            upd_q.push_back({hway, we, wdata});
            exp_lat = 2;
            if (exp_hit < 255) exp_hit++;
        end else begin
            if (vdirty) mem_q.push_back({1'b1, vtag, addr[0], vdata});
            mem_q.push_back({1'b0, addr, 3'd0});
            fill_q.push_back({vway, addr[3:1], rd, we});
            exp_lat = vdirty ? 4 + dw + dr : 3 + dr;
            if (exp_miss < 255) exp_miss++;
            if (vdirty && exp_wb < 255) exp_wb++;
        end
        wb0 = wb_seen;
        acc0 = acc_cnt;
        mreq_seen = 0;
        @(negedge clock);
        cpu_req_valid = 1'b1; cpu_req_we = we; cpu_req_addr = addr; cpu_req_wdata = wdata;
        @(negedge clock);
        check_eq({tag, "_lk_addr"}, {lk_tag, lk_index}, addr);
        check_eq({tag, "_ready_low"}, cpu_ready, 0);
        if (!hold) cpu_req_valid = 1'b0;
        cyc = 1;
        while (!cpu_resp_valid && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (hold && !cpu_resp_valid) check_eq({tag, "_ready_busy"}, cpu_ready, 0);
        end
        check_eq({tag, "_resp_seen"}, cpu_resp_valid, 1);
        check_eq({tag, "_latency"}, cyc, exp_lat);
        @(negedge clock);
        check_eq({tag, "_ready_back"}, cpu_ready, 1);
        cpu_req_valid = 1'b0;
        if (hold) check_eq({tag, "_accepts"}, acc_cnt - acc0, 1);
        check_eq({tag, "_wback_pulses"}, wb_seen - wb0, (!hit && vdirty) ? 1 : 0);
        if (hit) check_eq({tag, "_no_mem_req"}, mreq_seen, 0);
        check_counters(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cpu_req_valid = 0; cpu_req_we = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
        lk_hit = 0; lk_hit_way = 0; lk_hit_data = '0;
        lk_vic_way = 0; lk_vic_dirty = 0; lk_vic_tag = '0; lk_vic_data = '0;
        mem_ack = 0; mem_rdata = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("rst_ready", cpu_ready, 1);
        check_eq("rst_resp_valid", cpu_resp_valid, 0);
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_upd_fill", {upd_en, fill_en, wback}, 0);
        check_counters("rst");

        // read hit, clean read miss, dirty write miss, write hit
        do_access("t1_rd_hit", 0, 4'h9, 3'd0, 1, 1, 3'd5, 0, 0, 3'd0, 3'd0, 3'd0, 1, 1, 0);
        do_access("t2_rd_miss", 0, 4'h6, 3'd0, 0, 0, 3'd0, 0, 0, 3'd1, 3'd2, 3'd6, 1, 3, 0);
        do_access("t3_wr_dmiss", 1, 4'hB, 3'd3, 0, 0, 3'd0, 1, 1, 3'd2, 3'd7, 3'd4, 2, 1, 0);
        do_access("t3b_wr_hit", 1, 4'h2, 3'd1, 1, 0, 3'd6, 0, 0, 3'd0, 3'd0, 3'd0, 1, 1, 0);

        // reset while waiting for refill data
        lk_hit = 0; lk_vic_dirty = 0; lk_vic_way = 1; dly_rf = 50;
        @(negedge clock);
        cpu_req_valid = 1; cpu_req_we = 0; cpu_req_addr = 4'h3;
        @(negedge clock);
        cpu_req_valid = 0;
        for (int i = 0; i < 10 && !(mem_req && !mem_we); i++) @(negedge clock);
        check_eq("t4_in_refill", {mem_req, mem_we}, 2'b10);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        exp_hit = 0; exp_miss = 0; exp_wb = 0;
        check_eq("t4_mem_req", mem_req, 0);
        check_eq("t4_ready", cpu_ready, 1);
        check_eq("t4_fill", fill_en, 0);
        check_counters("t4");
        repeat (4) @(negedge clock);
        check_eq("t4_idle_ready", cpu_ready, 1);

        // five hits saturate the 2-bit counter at 3
        for (int i = 0; i < 5; i++)
            do_access("t5_hit", 0, 4'(i), 3'd0, 1, i[0], 3'(i + 1), 0, 0, 3'd0, 3'd0, 3'd0, 1, 1, 0);
        check_eq("t5_sat2", d2_hit_count, 3);
        check_eq("t5_cnt8", hit_count, 5);

        // stray mem_ack while idle must be ignored
        @(negedge clock);
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        check_eq("t5_ack_ready", cpu_ready, 1);
        check_eq("t5_ack_memreq", mem_req, 0);
        repeat (2) @(negedge clock);
        check_eq("t5_ack_idle", {cpu_ready, cpu_resp_valid, fill_en}, 3'b100);

        // request held valid through a dirty miss
        do_access("t6_hold", 0, 4'hC, 3'd0, 0, 0, 3'd0, 1, 0, 3'd1, 3'd5, 3'd2, 2, 2, 1);

        // mixed random traffic
        for (int i = 0; i < 12; i++) begin
            logic [3:0] a;
            logic [2:0] wd, hd, vt, vd, md;
            logic w, h, hw, vdrt, vw;
            a = 4'($urandom_range(0, 15)); wd = 3'($urandom_range(0, 7));
            hd = 3'($urandom_range(0, 7)); vt = 3'($urandom_range(0, 7));
            vd = 3'($urandom_range(0, 7)); md = 3'($urandom_range(0, 7));
            w = 1'($urandom_range(0, 1)); h = 1'($urandom_range(0, 1));
            hw = 1'($urandom_range(0, 1)); vdrt = 1'($urandom_range(0, 1));
            vw = 1'($urandom_range(0, 1));
            do_access("rnd", w, a, wd, h, hw, hd, vdrt, vw, vt, vd, md,
                      $urandom_range(1, 3), $urandom_range(1, 3), 0);
        end

        repeat (3) @(negedge clock);
        check_eq("end_queues_empty", resp_q.size() + upd_q.size() + fill_q.size() + mem_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
